// File: rtl/rotary_operand_loader.sv
// Rotary quadrature operand entry front end.
// Each quadrature pin is synchronised and debounced. A full detent (both pins
// high after both low) produces a one-cycle load strobe. Five strobes stage two
// 7-bit operands and an op bit, which are then published together.

// Per-pin synchroniser and debounce filter.
module rotary_operand_loader_pin #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Counter runs only while the synchronised pin disagrees with the filtered
  // value. The filter flips on the edge where the count would reach the limit.
  always_comb begin
    sync_d = {sync_q[0], raw};
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, counter and filtered-value registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
endmodule

module rotary_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ROT_A,
  input  logic       ROT_B,
  input  logic [3:0] num,
  output logic [6:0] a,
  output logic [6:0] b,
  output logic       op,
  output logic       operands_valid,
  output logic [2:0] phase,
  output logic       load_strobe
);
  localparam int NUM_PINS = 2;

  typedef enum logic [2:0] {
    LD_A_LO = 3'd0,
    LD_A_HI = 3'd1,
    LD_B_LO = 3'd2,
    LD_B_HI = 3'd3,
    LD_OP   = 3'd4,
    SHOW    = 3'd5
  } phase_e;

  logic [NUM_PINS-1:0] raw_pins;
  logic [NUM_PINS-1:0] filt_pins;

  assign raw_pins = {ROT_B, ROT_A};

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    rotary_operand_loader_pin #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pin (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_pins[p]),
      .filt (filt_pins[p])
    );
  end

  logic   evt_q, evt_d;
  logic   evt_prev_q;
  logic   strobe_q, strobe_d;
  phase_e state_q, state_d;
  logic [6:0] sa_q, sa_d, sb_q, sb_d;
  logic [6:0] a_q, a_d, b_q, b_d;
  logic       op_q, op_d;
  logic       valid_q, valid_d;

  // Detent event: set with both pins high, cleared with both low, held in the
  // mixed states so direction never matters. Strobe fires on its rising edge.
  always_comb begin
    evt_d = evt_q;
    if (&filt_pins)       evt_d = 1'b1;
    else if (~|filt_pins) evt_d = 1'b0;
    strobe_d = evt_q & ~evt_prev_q;
  end

  // Event, edge-history and strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_q      <= 1'b0;
      evt_prev_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      evt_q      <= evt_d;
      evt_prev_q <= evt_q;
      strobe_q   <= strobe_d;
    end
  end

  // Entry sequencer: each strobe captures one nibble into staging; the op
  // detent publishes the staged operands in one step so a/b never tear.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    case (state_q)
      LD_A_LO: if (strobe_q) begin sa_d[3:0] = num;      state_d = LD_A_HI; end
      LD_A_HI: if (strobe_q) begin sa_d[6:4] = num[2:0]; state_d = LD_B_LO; end
      LD_B_LO: if (strobe_q) begin sb_d[3:0] = num;      state_d = LD_B_HI; end
      LD_B_HI: if (strobe_q) begin sb_d[6:4] = num[2:0]; state_d = LD_OP;   end
      LD_OP: if (strobe_q) begin
        a_d     = sa_q;
        b_d     = sb_q;
        op_d    = num[0];
        valid_d = 1'b1;
        state_d = SHOW;
      end
      SHOW: if (strobe_q) begin
        valid_d = 1'b0;
        state_d = LD_A_LO;
      end
      default: state_d = LD_A_LO;
    endcase
  end

  // Sequencer, staging and output registers; reset overrides any strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LD_A_LO;
      sa_q    <= '0;
      sb_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign op             = op_q;
  assign operands_valid = valid_q;
  assign phase          = state_q;
  assign load_strobe    = strobe_q;
endmodule

// File: tb/tb_rotary_operand_loader.sv
// Self-checking bench for rotary_operand_loader with DEBOUNCE_CYCLES=4.
module tb_rotary_operand_loader;
  localparam int D = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ROT_A = 1'b0;
  logic       ROT_B = 1'b0;
  logic [3:0] num   = 4'h0;
  logic [6:0] a, b;
  logic       op, operands_valid, load_strobe;
  logic [2:0] phase;

  rotary_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ROT_A         (ROT_A),
    .ROT_B         (ROT_B),
    .num           (num),
    .a             (a),
    .b             (b),
    .op            (op),
    .operands_valid(operands_valid),
    .phase         (phase),
    .load_strobe   (load_strobe)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Strobe monitor: counts strobe-high cycles, remembers the edge that raised it.
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  always @(negedge clk) begin
    if (load_strobe === 1'b1) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
    end
  end

  int vecs = 0;
  int errs = 0;

  // Reference model at the detent level.
  int         m_ph;
  int         m_d[5];
  logic [6:0] m_a, m_b;
  logic       m_op, m_v;

  task automatic model_reset();
    m_ph = 0; m_a = 0; m_b = 0; m_op = 0; m_v = 0;
    for (int i = 0; i < 5; i++) m_d[i] = 0;
  endtask

  task automatic model_strobe(input int n);
    if (m_ph == 5) begin
      m_v  = 0;
      m_ph = 0;
    end else begin
      m_d[m_ph] = n;
      if (m_ph == 4) begin
        m_a  = 7'((m_d[1] % 8) * 16 + m_d[0]);
        m_b  = 7'((m_d[3] % 8) * 16 + m_d[2]);
        m_op = (m_d[4] % 2) == 1;
        m_v  = 1;
      end
      m_ph++;
    end
  endtask

  // One detent: A rises, B follows after 'skew' cycles, both later return low.
  task automatic detent(input logic [3:0] n, input int skew);
    int  nexp, start;
    bit  seen;
    @(posedge clk); #1;
    num   = n;
    ROT_A = 1'b1;
    if (skew > 0) begin
      repeat (skew) @(posedge clk);
      #1;
    end
    ROT_B = 1'b1;
    nexp  = cyc + 1;
    start = strobe_cnt;
    seen  = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk); #1;
      if (strobe_cnt != start) seen = 1;
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL strobe_timeout: got no strobe, required after edge %0d", nexp + D + 3);
    end else begin
      vecs++;
      if (last_strobe_cyc !== nexp + D + 3) begin
        errs++;
        $display("FAIL strobe_latency: got edge %0d, required edge %0d", last_strobe_cyc, nexp + D + 3);
      end
      model_strobe(int'(n));
      @(negedge clk); #1;
      vecs += 5;
      if (phase !== 3'(m_ph)) begin errs++; $display("FAIL phase: got %0d, required %0d", phase, m_ph); end
      if (a !== m_a) begin errs++; $display("FAIL a: got %h, required %h", a, m_a); end
      if (b !== m_b) begin errs++; $display("FAIL b: got %h, required %h", b, m_b); end
      if (op !== m_op) begin errs++; $display("FAIL op: got %b, required %b", op, m_op); end
      if (operands_valid !== m_v) begin errs++; $display("FAIL valid: got %b, required %b", operands_valid, m_v); end
    end
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    num   = 4'($urandom);
    repeat (D + 8) @(posedge clk);
    #1;
    vecs++;
    if (strobe_cnt !== start + 1) begin
      errs++;
      $display("FAIL strobe_width: got %0d strobe cycles, required 1", strobe_cnt - start);
    end
  endtask

  task automatic test_reset();
    int start;
    rst_n = 1'b0;
    start = strobe_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ROT_A = 1'($urandom);
      ROT_B = 1'($urandom);
      @(negedge clk); #1;
      vecs++;
      if ({a, b, op, operands_valid, phase, load_strobe} !== '0) begin
        errs++;
        $display("FAIL reset_outputs: got a=%h b=%h op=%b v=%b ph=%0d st=%b, required all 0",
                 a, b, op, operands_valid, phase, load_strobe);
      end
    end
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    vecs += 2;
    if (strobe_cnt !== start) begin errs++; $display("FAIL reset_strobe: got %0d strobes, required 0", strobe_cnt - start); end
    if (phase !== 3'd0) begin errs++; $display("FAIL reset_phase: got %0d, required 0", phase); end
    model_reset();
  endtask

  task automatic test_latency();
    detent(4'($urandom), 0);
  endtask

  task automatic test_glitch();
    int start;
    start = strobe_cnt;
    // Both pins pulsed shorter than the debounce window.
    for (int k = 1; k < D; k++) begin
      @(posedge clk); #1;
      ROT_A = 1'b1; ROT_B = 1'b1;
      repeat (k) @(posedge clk);
      #1;
      ROT_A = 1'b0; ROT_B = 1'b0;
      repeat (12) @(posedge clk);
    end
    // B stable high, A glitched: mixed state must not strobe.
    @(posedge clk); #1;
    ROT_B = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    ROT_A = 1'b1;
    repeat (D - 1) @(posedge clk);
    #1;
    ROT_A = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ROT_B = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    vecs += 2;
    if (strobe_cnt !== start) begin errs++; $display("FAIL glitch_strobe: got %0d strobes, required 0", strobe_cnt - start); end
    if (phase !== 3'(m_ph)) begin errs++; $display("FAIL glitch_phase: got %0d, required %0d", phase, m_ph); end
  endtask

  task automatic test_finish_round();
    while (m_ph != 0) detent(4'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_full_entry();
    logic [3:0] seq [5];
    seq = '{4'hA, 4'hD, 4'h3, 4'h5, 4'h1};
    for (int i = 0; i < 5; i++) detent(seq[i], int'($urandom_range(0, 3)));
    vecs += 4;
    if (a !== 7'h5A) begin errs++; $display("FAIL full_a: got %h, required 5a", a); end
    if (b !== 7'h53) begin errs++; $display("FAIL full_b: got %h, required 53", b); end
    if (op !== 1'b1) begin errs++; $display("FAIL full_op: got %b, required 1", op); end
    if (operands_valid !== 1'b1) begin errs++; $display("FAIL full_valid: got %b, required 1", operands_valid); end
    detent(4'($urandom), 1);
    vecs += 3;
    if (operands_valid !== 1'b0) begin errs++; $display("FAIL sixth_valid: got %b, required 0", operands_valid); end
    if (phase !== 3'd0) begin errs++; $display("FAIL sixth_phase: got %0d, required 0", phase); end
    if (a !== 7'h5A || b !== 7'h53) begin errs++; $display("FAIL sixth_hold: got a=%h b=%h, required 5a 53", a, b); end
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 6; i++) detent(4'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_reset_mid_entry();
    logic [3:0] seq [5];
    seq = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h0};
    for (int i = 0; i < 3; i++) detent(4'($urandom), int'($urandom_range(0, 2)));
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    vecs++;
    if ({a, b, op, operands_valid, phase} !== '0) begin
      errs++;
      $display("FAIL mid_reset: got a=%h b=%h op=%b v=%b ph=%0d, required all 0", a, b, op, operands_valid, phase);
    end
    for (int i = 0; i < 5; i++) detent(seq[i], 0);
    vecs += 3;
    if (a !== 7'h01) begin errs++; $display("FAIL mid_a: got %h, required 01", a); end
    if (b !== 7'h02) begin errs++; $display("FAIL mid_b: got %h, required 02", b); end
    if (op !== 1'b0) begin errs++; $display("FAIL mid_op: got %b, required 0", op); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_finish_round();
    test_full_entry();
    test_random_rounds();
    test_reset_mid_entry();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
